// File: rtl/regf_bus_arbiter.sv
// Two-client round-robin arbiter and bus sequencer for a 32x8 register file.
// Generates CS/OE/WS/ADDR timing, drives the data bus on writes only, and returns read data with a one-cycle ACK.
module regf_bus_arbiter #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 8,
  parameter int READ_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  inout  wire  [DATA_W-1:0] rf_data,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_oe,
  output logic              rf_ws,
  output logic              rf_cs,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RECOVER,
    S_RWAIT,
    S_DONE
  } state_t;

  localparam int                CNT_W     = 3;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(READ_WAIT - 1);

  state_t              state, state_nxt;
  logic                rr_ptr;
  logic                gnt_id;
  logic                gnt_we;
  logic [DATA_W-1:0]   gnt_wdata;
  logic [CNT_W-1:0]    wait_cnt;
  logic                any_req;
  logic                pick;
  logic                drive_en;
  logic                rwait_last;

  // Both requesting: the pointer decides; otherwise whoever is asking wins.
  assign any_req    = req0 | req1;
  assign pick       = (req0 && req1) ? rr_ptr : req1;
  assign rwait_last = (state == S_RWAIT) && (wait_cnt == WAIT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    state_nxt = state;
    rf_cs     = 1'b1;
    rf_oe     = 1'b0;
    rf_ws     = 1'b0;
    drive_en  = 1'b0;
    busy      = (state != S_IDLE);
    ack0      = 1'b0;
    ack1      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (any_req) state_nxt = S_SETUP;
      end
      S_SETUP: begin
        rf_cs     = 1'b0;
        rf_oe     = ~gnt_we;
        drive_en  = gnt_we;
        state_nxt = gnt_we ? S_STROBE : S_RWAIT;
      end
      S_STROBE: begin
        rf_cs     = 1'b0;
        rf_ws     = 1'b1;
        drive_en  = 1'b1;
        state_nxt = S_RECOVER;
      end
      S_RECOVER: begin
        rf_cs     = 1'b0;
        drive_en  = 1'b1;
        state_nxt = S_DONE;
      end
      S_RWAIT: begin
        rf_cs = 1'b0;
        rf_oe = 1'b1;
        if (rwait_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        ack0      = ~gnt_id;
        ack1      = gnt_id;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The bus is only ever driven in write states, where OE is low by construction.
  assign rf_data = drive_en ? gnt_wdata : {DATA_W{1'bz}};

  // NOTE: only control/data registers are reset here; there is no storage array to clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= 1'b0;
      gnt_id    <= 1'b0;
      gnt_we    <= 1'b0;
      gnt_wdata <= '0;
      rf_addr   <= '0;
      wait_cnt  <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      if (state == S_IDLE && any_req) begin
        gnt_id    <= pick;
        rr_ptr    <= ~pick;
        gnt_we    <= pick ? we1 : we0;
        rf_addr   <= pick ? addr1 : addr0;
        gnt_wdata <= pick ? wdata1 : wdata0;
      end
      if (state == S_SETUP) begin
        wait_cnt <= '0;
      end else if (state == S_RWAIT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (rwait_last) begin
        if (gnt_id) rdata1 <= rf_data;
        else        rdata0 <= rf_data;
      end
    end
  end

endmodule

// File: tb/tb_regf_bus_arbiter.sv
// Self-checking bench for regf_bus_arbiter: a transaction-level model predicts every
// bus/handshake output per cycle, and directed scenarios pin the model with literal values.
module tb_regf_bus_arbiter;

  localparam int READ_WAIT = 1;

  logic       clk;
  logic       rst_n;
  logic       req0, we0, req1, we1;
  logic [4:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  wire  [7:0] rf_data;
  logic [4:0] rf_addr;
  logic       rf_oe, rf_ws, rf_cs, busy;

  int checks = 0;
  int errors = 0;

  regf_bus_arbiter #(.ADDR_W(5), .DATA_W(8), .READ_WAIT(READ_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .rf_data(rf_data), .rf_addr(rf_addr), .rf_oe(rf_oe), .rf_ws(rf_ws), .rf_cs(rf_cs),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file device: drives the bus on reads, stores on the write strobe.
  logic [7:0] dev_mem [32];
  assign rf_data = (!rf_cs && rf_oe) ? dev_mem[rf_addr] : 8'bz;
  always @(posedge clk) begin
    if (!rf_cs && rf_ws) dev_mem[rf_addr] <= rf_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: m_k counts cycles since the grant edge (0 = idle).
  int         m_k, m_len, m_id, m_ptr;
  logic       m_we;
  logic [4:0] m_addr, m_last_addr;
  logic [7:0] m_wdata;
  logic [7:0] exp_mem [32];
  logic [7:0] exp_rdata [2];

  task automatic m_reset();
    m_k = 0; m_len = 0; m_id = 0; m_ptr = 0; m_we = 1'b0;
    m_addr = '0; m_last_addr = '0; m_wdata = '0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
  endtask

  task automatic model_step();
    if (m_k == 0) begin
      if (req0 || req1) begin
        m_id        = (req0 && req1) ? m_ptr : (req1 ? 1 : 0);
        m_ptr       = 1 - m_id;
        m_we        = (m_id == 1) ? we1 : we0;
        m_addr      = (m_id == 1) ? addr1 : addr0;
        m_wdata     = (m_id == 1) ? wdata1 : wdata0;
        m_last_addr = m_addr;
        m_len       = m_we ? 4 : 2 + READ_WAIT;
        m_k         = 1;
      end
    end else if (m_k == m_len) begin
      m_k = 0;
    end else begin
      if (m_we && m_k == 2) exp_mem[m_addr] = m_wdata;
      if (!m_we && m_k == m_len - 1) exp_rdata[m_id] = exp_mem[m_addr];
      m_k++;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      exp_mem[i] = '0;
      dev_mem[i] = '0;
    end
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        model_step();
    end
  end

  task automatic compare_cycle();
    logic bus_on;
    bus_on = (m_k >= 1) && (m_k < m_len);
    check("rf_cs",    32'(rf_cs),  32'(!bus_on));
    check("rf_oe",    32'(rf_oe),  32'(bus_on && !m_we));
    check("rf_ws",    32'(rf_ws),  32'(m_k == 2 && m_we));
    check("busy",     32'(busy),   32'(m_k != 0));
    check("ack0",     32'(ack0),   32'(m_k != 0 && m_k == m_len && m_id == 0));
    check("ack1",     32'(ack1),   32'(m_k != 0 && m_k == m_len && m_id == 1));
    check("rf_addr",  32'(rf_addr), 32'(m_last_addr));
    check("rdata0",   32'(rdata0), 32'(exp_rdata[0]));
    check("rdata1",   32'(rdata1), 32'(exp_rdata[1]));
    check("ws_guard", 32'(rf_ws && (rf_oe || rf_cs)), 32'(0));
    if (bus_on && m_we)  check("wr_bus", 32'(rf_data), 32'(m_wdata));
    if (bus_on && !m_we) check("rd_bus", 32'(rf_data), 32'(exp_mem[m_addr]));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) compare_cycle();
    end
  end

  int ack_log[$];
  initial begin
    forever begin
      @(negedge clk);
      if (ack0) ack_log.push_back(0);
      if (ack1) ack_log.push_back(1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_txn(input int id, input logic we, input logic [4:0] addr,
                        input logic [7:0] wd, output logic [7:0] rd, output int lat);
    logic got;
    @(negedge clk);
    if (id == 0) begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd;
    end
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      lat++;
      if ((id == 0 && ack0) || (id == 1 && ack1)) begin
        got = 1'b1;
        break;
      end
    end
    check("ack_seen", 32'(got), 32'(1));
    rd = (id == 0) ? rdata0 : rdata1;
    if (id == 0) req0 = 1'b0;
    else         req1 = 1'b0;
  endtask

  logic [7:0] rd_a, rd_b, rd_c, rd_d;
  int         lat_a, lat_b;

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    check("rst_cs",     32'(rf_cs),   32'(1));
    check("rst_oe",     32'(rf_oe),   32'(0));
    check("rst_ws",     32'(rf_ws),   32'(0));
    check("rst_busy",   32'(busy),    32'(0));
    check("rst_ack",    32'({ack0, ack1}), 32'(0));
    check("rst_rdata",  32'({rdata0, rdata1}), 32'(0));
    check("rst_addr",   32'(rf_addr), 32'(0));
    #2 rst_n = 1'b1;

    // Simultaneous requests from reset: grants alternate 0,1,0,1.
    ack_log.delete();
    fork
      begin
        do_txn(0, 1'b1, 5'd1, 8'h11, rd_a, lat_a);
        do_txn(0, 1'b1, 5'd2, 8'h22, rd_a, lat_a);
      end
      begin
        do_txn(1, 1'b0, 5'd1, 8'hA5, rd_b, lat_b);
        do_txn(1, 1'b0, 5'd2, 8'hA5, rd_c, lat_b);
      end
    join
    check("rr_count", 32'(ack_log.size()), 32'(4));
    if (ack_log.size() == 4) begin
      check("rr_order0", 32'(ack_log[0]), 32'(0));
      check("rr_order1", 32'(ack_log[1]), 32'(1));
      check("rr_order2", 32'(ack_log[2]), 32'(0));
      check("rr_order3", 32'(ack_log[3]), 32'(1));
    end
    check("rr_read1", 32'(rd_b), 32'(8'h11));
    check("rr_read2", 32'(rd_c), 32'(8'h22));

    // Single write then single read of the same address.
    do_txn(0, 1'b1, 5'd5, 8'd31, rd_a, lat_a);
    check("wr_latency", 32'(lat_a), 32'(4));
    do_txn(1, 1'b0, 5'd5, 8'hA5, rd_b, lat_b);
    check("rd_latency", 32'(lat_b), 32'(3));
    check("rd_data5",   32'(rd_b),  32'(31));
    check("rdata0_untouched", 32'(rdata0), 32'(0));

    // Inputs change (and REQ drops) after the grant: latched values win.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd7; wdata0 = 8'h44;
    @(negedge clk);
    addr0 = 5'd9; wdata0 = 8'h99; req0 = 1'b0;
    check("latched_addr", 32'(rf_addr), 32'(7));
    check("latched_data", 32'(rf_data), 32'(8'h44));
    lat_a = 0;
    for (int i = 0; i < 16; i++) begin
      if (ack0) break;
      @(negedge clk);
      lat_a++;
    end
    check("early_drop_ack", 32'(ack0), 32'(1));
    do_txn(1, 1'b0, 5'd7, 8'hA5, rd_b, lat_b);
    check("latched_write7", 32'(rd_b), 32'(8'h44));
    do_txn(1, 1'b0, 5'd9, 8'hA5, rd_b, lat_b);
    check("untouched9", 32'(rd_b), 32'(0));

    // Asynchronous reset in the middle of the write strobe.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd3; wdata0 = 8'h77;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_ws", 32'(rf_ws), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst_ws",    32'(rf_ws),   32'(0));
    check("arst_cs",    32'(rf_cs),   32'(1));
    check("arst_oe",    32'(rf_oe),   32'(0));
    check("arst_busy",  32'(busy),    32'(0));
    check("arst_addr",  32'(rf_addr), 32'(0));
    check("arst_rdata", 32'({rdata0, rdata1}), 32'(0));
    check("arst_bus_released", 32'(rf_data !== 8'h77), 32'(1));
    req0 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Full sweep: client 0 writes 30+k everywhere, client 1 reads it all back.
    for (int k = 0; k < 32; k++) begin
      do_txn(0, 1'b1, 5'(k), 8'(30 + k), rd_a, lat_a);
    end
    for (int k = 0; k < 32; k++) begin
      do_txn(1, 1'b0, 5'(k), 8'hA5, rd_d, lat_b);
      check("sweep_read", 32'(rd_d), 32'(30 + k));
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regf_bus_arbiter.md
Name: regf_bus_arbiter

Overview:
Two-port round-robin arbiter and bus sequencer for the 32x8 register file (CS active-low, OE high = read, WS high-pulse write strobe, bidirectional 8-bit DATA).
Two client requesters issue single-word read/write transactions. The block grants one requester at a time and generates the file's CS/OE/WS/ADDR timing. It drives the shared DATA bus only during writes and returns read data and a one-cycle ACK to the winning client.

Parameters:
ADDR_W, 5, register file address width (32 entries)
DATA_W, 8, data word width
READ_WAIT, 1, cycles the bus is held in read mode before RF_DATA is sampled (1..4)

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
REQ0  input  1  client 0 transaction request, held until ACK0
WE0  input  1  client 0: 1 = write, 0 = read
ADDR0  input  ADDR_W  client 0 address
WDATA0  input  DATA_W  client 0 write data
ACK0  output  1  client 0 completion pulse, one cycle
RDATA0  output  DATA_W  client 0 read data, valid with ACK0, held until next client-0 read
REQ1/WE1/ADDR1/WDATA1/ACK1/RDATA1  same as client 0 for client 1
RF_DATA  inout  DATA_W  register file data bus
RF_ADDR  output  ADDR_W  register file address
RF_OE  output  1  1 = file drives bus (read), 0 = write direction
RF_WS  output  1  write strobe, one-cycle high pulse
RF_CS  output  1  chip select, active low
BUSY  output  1  high in every non-IDLE state

Behaviour:
- Clock and reset: single clock CLK; reset is asynchronous, active-low (RST_N).
- Reset, immediate and asynchronous, including mid-transaction:
  - state = IDLE, RF_CS = 1, RF_OE = 0, RF_WS = 0, RF_ADDR = 0, RF_DATA = Z.
  - ACK0/ACK1 = 0, RDATA0/RDATA1 = 0, BUSY = 0, round-robin pointer = client 0.
- FSM states: IDLE, SETUP, STROBE, RECOVER, RWAIT, DONE.
- IDLE:
  - Arbitrates on each rising edge.
  - Only one REQ high: that client is granted.
  - Both high: the client named by the pointer is granted, and the pointer flips to the other client.
  - Single grant: pointer set to the non-granted client.
  - On grant, latch client id, WE, ADDR and WDATA into internal regs, then go to SETUP. Later changes on client inputs are ignored until DONE.
- SETUP (1 cycle):
  - RF_CS = 0, RF_ADDR = latched address.
  - Write: RF_OE = 0, RF_DATA driven with latched data; next state STROBE.
  - Read: RF_OE = 1, RF_DATA = Z; next state RWAIT.
- STROBE (1 cycle, write only): RF_WS = 1, CS/OE/ADDR/DATA held; next state RECOVER.
- RECOVER (1 cycle): RF_WS = 0, data still driven (hold time); next state DONE.
- RWAIT (READ_WAIT cycles, counter-based): RF_CS = 0, RF_OE = 1, bus Z. On the edge leaving the final RWAIT cycle, RF_DATA is captured into the granted client's RDATA; next state DONE.
- DONE (1 cycle):
  - RF_CS = 1, RF_OE = 0, RF_WS = 0, bus Z; RF_ADDR holds its last value.
  - ACK of the granted client = 1; next state IDLE.
- Latency from grant edge to ACK high: write = 4 cycles; read = 2 + READ_WAIT cycles. At least one IDLE cycle separates transactions.
- Bus contention rule: RF_DATA is driven only when RF_CS = 0 and RF_OE = 0 and the state is SETUP/STROBE/RECOVER. There is never a cycle where RF_OE = 1 and RF_DATA is driven.
- RF_WS is never high while RF_OE = 1 or RF_CS = 1.
- Client protocol:
  - A client drops REQ in the cycle after ACK.
  - REQ still high in the IDLE after DONE counts as a new request. Round-robin prevents starvation of the other client.
- REQ deasserted before ACK: the transaction still completes and ACK is still pulsed.
- Non-granted client's RDATA is never modified.
- Addresses 0..31 pass through unmodified; no wrap logic needed.

Test Plan:
- Reset: assert RST_N=0 mid-STROBE -> RF_WS=0, RF_CS=1, RF_DATA=Z, BUSY=0 immediately, without waiting for a clock edge.
- Write: REQ0=1, WE0=1, ADDR0=5, WDATA0=8'd31 -> SETUP with CS=0/OE=0/DATA=31, then one WS pulse, then ACK0 high exactly 4 cycles after grant.
- Read: REQ1=1, WE1=0, ADDR1=5 (READ_WAIT=1) -> RF_OE=1, bus Z from the controller, RDATA1=31 with ACK1 3 cycles after grant.
- Contention: REQ0 and REQ1 asserted in the same cycle from reset -> client 0 served first, then client 1. With both held, grants alternate 0,1,0,1 over 4 transactions.
- Sweep: client 0 writes ADDR k with data 30+k for k=0..31, then client 1 reads all 32 -> every RDATA1 = 30+k. No cycle with RF_OE=1 and the bus driven; WS never high with CS=1.
- Input change: after grant, change ADDR0 from 7 to 9 and WDATA0 -> RF_ADDR stays 7 and the latched data is written.
